// File: rtl/instruction_fetch_unit_pkg.sv
// Shared definitions for the IF stage: FSM encoding, default constants and
// small PC helper functions used by the fetch unit and its IF/ID register.
package instruction_fetch_unit_pkg;

    // Fetch FSM states.
    // S_REQ  : a request is being offered to instruction memory
    // S_WAIT : one request accepted, waiting for its response
    // S_HOLD : response captured in the hold buffer while ID is stalled
    // S_DROP : the outstanding response belongs to a killed path
    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2,
        S_DROP = 2'd3
    } fetch_state_t;

    // Default first fetch address after reset.
    localparam logic [31:0] DEFAULT_RESET_PC  = 32'h0000_0000;

    // Bubble instruction: ADDI x0,x0,0.
    localparam logic [31:0] DEFAULT_NOP_INSTR = 32'h0000_0013;

    // Width of the instruction word and of the program counter.
    localparam int unsigned XLEN = 32;

    // Sequential fetch address; wraps modulo 2^32.
    function automatic logic [31:0] next_fetch_pc(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

    // Force a word-aligned address by clearing the two low bits.
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

    // True when an address is not a multiple of four.
    function automatic logic is_misaligned(input logic [31:0] addr);
        return (addr[1:0] != 2'b00);
    endfunction

endpackage

// File: rtl/instruction_fetch_unit_if_id_register.sv
// IF/ID pipeline register plus a one-entry hold buffer. The hold buffer
// catches a fetched word that arrives while the ID stage is stalled so the
// memory response is never lost.
module if_id_register
    import instruction_fetch_unit_pkg::*;
#(
    parameter logic [31:0] NOP_INSTR = DEFAULT_NOP_INSTR
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        stall,
    input  logic        load,
    input  logic        hold_write,
    input  logic        hold_release,
    input  logic [31:0] rsp_instr,
    input  logic [31:0] rsp_pc,
    output logic [31:0] id_instruction,
    output logic [31:0] id_pc,
    output logic        id_valid
);

    logic [31:0] hold_instr;
    logic [31:0] hold_pc;
    logic        hold_valid;

    // ID register and hold buffer update; flush beats stall, a direct load
    // beats draining the buffer, and an idle unstalled cycle inserts a bubble.
    always_ff @(posedge clk) begin
        if (rst) begin
            id_instruction <= NOP_INSTR;
            id_pc          <= 32'h0000_0000;
            id_valid       <= 1'b0;
            hold_instr     <= NOP_INSTR;
            hold_pc        <= 32'h0000_0000;
            hold_valid     <= 1'b0;
        end else if (flush) begin
            id_instruction <= NOP_INSTR;
            id_valid       <= 1'b0;
            hold_valid     <= 1'b0;
        end else begin
            if (load) begin
                id_instruction <= rsp_instr;
                id_pc          <= rsp_pc;
                id_valid       <= 1'b1;
            end else if (hold_release && hold_valid) begin
                id_instruction <= hold_instr;
                id_pc          <= hold_pc;
                id_valid       <= 1'b1;
                hold_valid     <= 1'b0;
            end else if (!stall) begin
                id_instruction <= NOP_INSTR;
                id_valid       <= 1'b0;
            end

            if (hold_write) begin
                hold_instr <= rsp_instr;
                hold_pc    <= rsp_pc;
                hold_valid <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/instruction_fetch_unit.sv
// IF stage of the pipelined RV32I core: owns the PC, the instruction memory
// request/response handshake (one request outstanding at most), redirect
// handling with response dropping, and feeds the IF/ID register.
module instruction_fetch_unit
    import instruction_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = DEFAULT_RESET_PC,
    parameter logic [31:0] NOP_INSTR = DEFAULT_NOP_INSTR
) (
    input  logic        clk_i,
    input  logic        rst_i,
    output logic        Imem_req_valid_o,
    input  logic        Imem_req_ready_i,
    output logic [31:0] Imem_addr_o,
    input  logic        Imem_rsp_valid_i,
    input  logic [31:0] Imem_rsp_data_i,
    input  logic        Redirect_en_i,
    input  logic [31:0] Redirect_pc_i,
    input  logic        Stall_i,
    output logic [31:0] ID_Instruction_o,
    output logic [31:0] ID_PC_o,
    output logic        ID_Valid_o,
    output logic        Misalign_o
);

    fetch_state_t state;
    logic [31:0]  pc;
    logic [31:0]  req_pc;
    logic         misalign_q;

    logic         id_load;
    logic         id_hold_write;
    logic         id_hold_release;
    logic         req_fire;

    // The request is only offered in S_REQ and is squashed during reset.
    assign Imem_req_valid_o = (state == S_REQ) && !rst_i;
    assign Imem_addr_o      = pc;
    assign Misalign_o       = misalign_q;
    assign req_fire         = Imem_req_valid_o && Imem_req_ready_i;

    // Decode how the IF/ID register should treat this cycle's response.
    always_comb begin
        id_load         = 1'b0;
        id_hold_write   = 1'b0;
        id_hold_release = 1'b0;
        if (!Redirect_en_i) begin
            case (state)
                S_WAIT: begin
                    if (Imem_rsp_valid_i) begin
                        if (Stall_i) begin
                            id_hold_write = 1'b1;
                        end else begin
                            id_load = 1'b1;
                        end
                    end
                end
                S_HOLD: begin
                    if (!Stall_i) begin
                        id_hold_release = 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Fetch FSM, PC and misalign pulse; a redirect overrides every state action.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state      <= S_REQ;
            pc         <= word_align(RESET_PC);
            req_pc     <= word_align(RESET_PC);
            misalign_q <= 1'b0;
        end else if (Redirect_en_i) begin
            pc         <= word_align(Redirect_pc_i);
            misalign_q <= is_misaligned(Redirect_pc_i);
            case (state)
                S_REQ:   state <= Imem_req_ready_i ? S_DROP : S_REQ;
                S_WAIT:  state <= Imem_rsp_valid_i ? S_REQ : S_DROP;
                S_HOLD:  state <= S_REQ;
                S_DROP:  state <= Imem_rsp_valid_i ? S_REQ : S_DROP;
                default: state <= S_REQ;
            endcase
        end else begin
            misalign_q <= 1'b0;
            case (state)
                S_REQ: begin
                    if (req_fire) begin
                        req_pc <= pc;
                        pc     <= next_fetch_pc(pc);
                        state  <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (Imem_rsp_valid_i) begin
                        state <= Stall_i ? S_HOLD : S_REQ;
                    end
                end
                S_HOLD: begin
                    if (!Stall_i) begin
                        state <= S_REQ;
                    end
                end
                S_DROP: begin
                    if (Imem_rsp_valid_i) begin
                        state <= S_REQ;
                    end
                end
                default: state <= S_REQ;
            endcase
        end
    end

    if_id_register #(
        .NOP_INSTR(NOP_INSTR)
    ) u_if_id_register (
        .clk            (clk_i),
        .rst            (rst_i),
        .flush          (Redirect_en_i),
        .stall          (Stall_i),
        .load           (id_load),
        .hold_write     (id_hold_write),
        .hold_release   (id_hold_release),
        .rsp_instr      (Imem_rsp_data_i),
        .rsp_pc         (req_pc),
        .id_instruction (ID_Instruction_o),
        .id_pc          (ID_PC_o),
        .id_valid       (ID_Valid_o)
    );

    // A response may only arrive while a request is outstanding.
    rsp_only_when_outstanding: assert property (
        @(posedge clk_i) disable iff (rst_i)
        !(Imem_rsp_valid_i && (state == S_REQ || state == S_HOLD))
    );

    // Fetch addresses are always word aligned.
    fetch_addr_aligned: assert property (
        @(posedge clk_i) disable iff (rst_i)
        Imem_addr_o[1:0] == 2'b00
    );

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed testbench for instruction_fetch_unit: sequential fetch,
// memory backpressure, ID stall with hold buffer, redirects and misalign.
module tb_instruction_fetch_unit;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] addr;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic        redirect_en;
    logic [31:0] redirect_pc;
    logic        stall;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic        id_valid;
    logic        misalign;

    int checks;
    int failures;

    instruction_fetch_unit dut (
        .clk_i            (clk),
        .rst_i            (rst),
        .Imem_req_valid_o (req_valid),
        .Imem_req_ready_i (req_ready),
        .Imem_addr_o      (addr),
        .Imem_rsp_valid_i (rsp_valid),
        .Imem_rsp_data_i  (rsp_data),
        .Redirect_en_i    (redirect_en),
        .Redirect_pc_i    (redirect_pc),
        .Stall_i          (stall),
        .ID_Instruction_o (id_instr),
        .ID_PC_o          (id_pc),
        .ID_Valid_o       (id_valid),
        .Misalign_o       (misalign)
    );

    // 10-time-unit clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock and settle just after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; req_ready = 1'b1; rsp_valid = 1'b0; rsp_data = 32'h0;
        redirect_en = 1'b0; redirect_pc = 32'h0; stall = 1'b0;
        tick();
        tick();
        checks++; if (req_valid !== 1'b0) begin failures++; $display("[TB] FAIL rst_req_valid: got %0h expected 0", req_valid); end
        checks++; if (id_valid !== 1'b0) begin failures++; $display("[TB] FAIL rst_id_valid: got %0h expected 0", id_valid); end
        checks++; if (id_instr !== NOP) begin failures++; $display("[TB] FAIL rst_id_instr: got %h expected %h", id_instr, NOP); end
        checks++; if (id_pc !== 32'h0) begin failures++; $display("[TB] FAIL rst_id_pc: got %h expected 0", id_pc); end
        checks++; if (misalign !== 1'b0) begin failures++; $display("[TB] FAIL rst_misalign: got %0h expected 0", misalign); end
        rst = 1'b0;
        #1;
        checks++; if (req_valid !== 1'b1) begin failures++; $display("[TB] FAIL rel_req_valid: got %0h expected 1", req_valid); end
        checks++; if (addr !== 32'h0) begin failures++; $display("[TB] FAIL rel_addr: got %h expected 0", addr); end
    endtask

    task automatic test_sequential_fetch();
        req_ready = 1'b1; rsp_valid = 1'b0;
        tick();
        checks++; if (req_valid !== 1'b0) begin failures++; $display("[TB] FAIL seq_wait_noreq: got %0h expected 0", req_valid); end
        req_ready = 1'b0; rsp_valid = 1'b1; rsp_data = 32'h0050_0093;
        tick();
        checks++; if (id_valid !== 1'b1) begin failures++; $display("[TB] FAIL seq0_valid: got %0h expected 1", id_valid); end
        checks++; if (id_pc !== 32'h0) begin failures++; $display("[TB] FAIL seq0_pc: got %h expected 0", id_pc); end
        checks++; if (id_instr !== 32'h0050_0093) begin failures++; $display("[TB] FAIL seq0_instr: got %h expected 00500093", id_instr); end
        checks++; if (addr !== 32'h4) begin failures++; $display("[TB] FAIL seq1_addr: got %h expected 4", addr); end
        req_ready = 1'b1; rsp_valid = 1'b0;
        tick();
        checks++; if (id_valid !== 1'b0) begin failures++; $display("[TB] FAIL seq_bubble: got %0h expected 0", id_valid); end
        req_ready = 1'b0; rsp_valid = 1'b1; rsp_data = 32'h0060_0113;
        tick();
        checks++; if (id_pc !== 32'h4) begin failures++; $display("[TB] FAIL seq1_pc: got %h expected 4", id_pc); end
        checks++; if (id_instr !== 32'h0060_0113) begin failures++; $display("[TB] FAIL seq1_instr: got %h expected 00600113", id_instr); end
        rsp_valid = 1'b0;
    endtask

    task automatic test_backpressure();
        int accepts;
        accepts = 0;
        req_ready = 1'b0; rsp_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (req_valid && req_ready) accepts++;
            tick();
            checks++; if (req_valid !== 1'b1 || addr !== 32'h8) begin failures++; $display("[TB] FAIL bp_hold%0d: got valid=%0h addr=%h expected 1/8", i, req_valid, addr); end
        end
        req_ready = 1'b1;
        if (req_valid && req_ready) accepts++;
        tick();
        checks++; if (req_valid !== 1'b0) begin failures++; $display("[TB] FAIL bp_wait: got %0h expected 0", req_valid); end
        checks++; if (accepts !== 1) begin failures++; $display("[TB] FAIL bp_accepts: got %0d expected 1", accepts); end
        req_ready = 1'b0; rsp_valid = 1'b1; rsp_data = 32'h0070_0213;
        tick();
        checks++; if (id_pc !== 32'h8) begin failures++; $display("[TB] FAIL bp_id_pc: got %h expected 8", id_pc); end
        checks++; if (addr !== 32'hC) begin failures++; $display("[TB] FAIL bp_next_addr: got %h expected c", addr); end
        rsp_valid = 1'b0;
    endtask

    task automatic test_stall_hold();
        req_ready = 1'b1; rsp_valid = 1'b0;
        tick();
        req_ready = 1'b0; rsp_valid = 1'b1; rsp_data = 32'h0080_0293;
        tick();
        checks++; if (addr !== 32'h10) begin failures++; $display("[TB] FAIL st_addr: got %h expected 10", addr); end
        req_ready = 1'b1; rsp_valid = 1'b0;
        tick();
        req_ready = 1'b0; stall = 1'b1; rsp_valid = 1'b1; rsp_data = 32'h00A0_0193;
        tick();
        checks++; if (req_valid !== 1'b0) begin failures++; $display("[TB] FAIL st_noreq: got %0h expected 0", req_valid); end
        checks++; if (id_pc !== 32'hC || id_valid !== 1'b0) begin failures++; $display("[TB] FAIL st_frozen: got pc=%h valid=%0h expected c/0", id_pc, id_valid); end
        rsp_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (req_valid !== 1'b0 || id_valid !== 1'b0 || id_instr !== NOP) begin failures++; $display("[TB] FAIL st_hold%0d: got req=%0h valid=%0h instr=%h expected 0/0/%h", i, req_valid, id_valid, id_instr, NOP); end
        end
        stall = 1'b0;
        tick();
        checks++; if (id_instr !== 32'h00A0_0193) begin failures++; $display("[TB] FAIL st_rel_instr: got %h expected 00a00193", id_instr); end
        checks++; if (id_pc !== 32'h10 || id_valid !== 1'b1) begin failures++; $display("[TB] FAIL st_rel_pc: got pc=%h valid=%0h expected 10/1", id_pc, id_valid); end
        checks++; if (req_valid !== 1'b1 || addr !== 32'h14) begin failures++; $display("[TB] FAIL st_resume: got valid=%0h addr=%h expected 1/14", req_valid, addr); end
    endtask

    task automatic test_redirect_outstanding();
        req_ready = 1'b1; rsp_valid = 1'b0;
        tick();
        req_ready = 1'b0; redirect_en = 1'b1; redirect_pc = 32'h100;
        tick();
        checks++; if (req_valid !== 1'b0 || id_valid !== 1'b0) begin failures++; $display("[TB] FAIL ro_drop: got req=%0h valid=%0h expected 0/0", req_valid, id_valid); end
        checks++; if (misalign !== 1'b0) begin failures++; $display("[TB] FAIL ro_misalign: got %0h expected 0", misalign); end
        redirect_en = 1'b0; rsp_valid = 1'b1; rsp_data = 32'hDEAD_BEEF;
        tick();
        checks++; if (id_valid !== 1'b0 || id_instr !== NOP) begin failures++; $display("[TB] FAIL ro_discard: got valid=%0h instr=%h expected 0/%h", id_valid, id_instr, NOP); end
        checks++; if (req_valid !== 1'b1 || addr !== 32'h100) begin failures++; $display("[TB] FAIL ro_target: got valid=%0h addr=%h expected 1/100", req_valid, addr); end
        rsp_valid = 1'b0; req_ready = 1'b1;
        tick();
        checks++; if (id_valid !== 1'b0) begin failures++; $display("[TB] FAIL ro_bubble: got %0h expected 0", id_valid); end
        req_ready = 1'b0; rsp_valid = 1'b1; rsp_data = 32'h0090_0313;
        tick();
        checks++; if (id_valid !== 1'b1 || id_pc !== 32'h100 || id_instr !== 32'h0090_0313) begin failures++; $display("[TB] FAIL ro_target_instr: got valid=%0h pc=%h instr=%h expected 1/100/00900313", id_valid, id_pc, id_instr); end
        rsp_valid = 1'b0;
    endtask

    task automatic test_redirect_with_rsp_stall();
        req_ready = 1'b1; stall = 1'b1;
        tick();
        checks++; if (id_valid !== 1'b1 || id_pc !== 32'h100) begin failures++; $display("[TB] FAIL rs_stall_hold: got valid=%0h pc=%h expected 1/100", id_valid, id_pc); end
        req_ready = 1'b0; redirect_en = 1'b1; redirect_pc = 32'h300; rsp_valid = 1'b1; rsp_data = 32'h1111_1111;
        tick();
        checks++; if (id_valid !== 1'b0 || id_instr !== NOP) begin failures++; $display("[TB] FAIL rs_flush: got valid=%0h instr=%h expected 0/%h", id_valid, id_instr, NOP); end
        checks++; if (req_valid !== 1'b1 || addr !== 32'h300) begin failures++; $display("[TB] FAIL rs_target: got valid=%0h addr=%h expected 1/300", req_valid, addr); end
        redirect_en = 1'b0; rsp_valid = 1'b0; stall = 1'b0; req_ready = 1'b1;
        tick();
        req_ready = 1'b0; rsp_valid = 1'b1; rsp_data = 32'h00B0_0393;
        tick();
        checks++; if (id_valid !== 1'b1 || id_pc !== 32'h300 || id_instr !== 32'h00B0_0393) begin failures++; $display("[TB] FAIL rs_resume: got valid=%0h pc=%h instr=%h expected 1/300/00b00393", id_valid, id_pc, id_instr); end
        rsp_valid = 1'b0;
    endtask

    task automatic test_misalign();
        req_ready = 1'b0; redirect_en = 1'b1; redirect_pc = 32'h202;
        tick();
        checks++; if (misalign !== 1'b1) begin failures++; $display("[TB] FAIL ma_pulse: got %0h expected 1", misalign); end
        checks++; if (req_valid !== 1'b1 || addr !== 32'h200) begin failures++; $display("[TB] FAIL ma_addr: got valid=%0h addr=%h expected 1/200", req_valid, addr); end
        redirect_en = 1'b0;
        tick();
        checks++; if (misalign !== 1'b0) begin failures++; $display("[TB] FAIL ma_clear: got %0h expected 0", misalign); end
        checks++; if (addr !== 32'h200) begin failures++; $display("[TB] FAIL ma_stable: got %h expected 200", addr); end
    endtask

    task automatic test_redirect_on_accept();
        req_ready = 1'b1; redirect_en = 1'b1; redirect_pc = 32'h40;
        tick();
        checks++; if (req_valid !== 1'b0) begin failures++; $display("[TB] FAIL ra_drop: got %0h expected 0", req_valid); end
        redirect_en = 1'b0; req_ready = 1'b0; rsp_valid = 1'b1; rsp_data = 32'h2222_2222;
        tick();
        checks++; if (req_valid !== 1'b1 || addr !== 32'h40 || id_valid !== 1'b0) begin failures++; $display("[TB] FAIL ra_resume: got req=%0h addr=%h valid=%0h expected 1/40/0", req_valid, addr, id_valid); end
        rsp_valid = 1'b0;
    endtask

    task automatic test_reset_mid_op();
        req_ready = 1'b1;
        tick();
        rst = 1'b1; req_ready = 1'b0;
        tick();
        checks++; if (req_valid !== 1'b0 || id_valid !== 1'b0 || id_pc !== 32'h0) begin failures++; $display("[TB] FAIL rm_state: got req=%0h valid=%0h pc=%h expected 0/0/0", req_valid, id_valid, id_pc); end
        rst = 1'b0;
        #1;
        checks++; if (req_valid !== 1'b1 || addr !== 32'h0) begin failures++; $display("[TB] FAIL rm_restart: got valid=%0h addr=%h expected 1/0", req_valid, addr); end
    endtask

    // Run the directed scenarios in order; each one starts where the last ended.
    initial begin
        checks = 0;
        failures = 0;
        test_reset();
        test_sequential_fetch();
        test_backpressure();
        test_stall_hold();
        test_redirect_outstanding();
        test_redirect_with_rsp_stall();
        test_misalign();
        test_redirect_on_accept();
        test_reset_mid_op();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
